// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Runs M-extension (mul/div) instructions from EX through the shared iterative
// multiply/divide unit (MDU). On issue it latches the operands and sends a
// one-cycle start pulse. It stalls EX until writeback takes the result, and it
// holds that result in a buffer for writeback. It also handles pipeline
// flushes and aborts a hung MDU with a watchdog.
//
// Optional build macro: MDU_FASTPATH_EN
//   When defined, an issued DIV/DIVU/REM/REMU with a zero divisor skips the
//   MDU. The RISC-V divide-by-zero result goes straight into the buffer.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   ex_valid, ex_is_mul_div  EX holds a valid M-extension instruction
//   ex_funct3, ex_word_op    operation select and W-form flag
//   ex_rs1, ex_rs2, ex_rd    operands and destination register
//   flush                    kill the EX instruction and any op in flight
//   wb_ready                 writeback accepts the buffered result
//   mdu_start/op/word/a/b    issue interface to the MDU (start is a pulse)
//   mdu_kill                 one-cycle abort to the MDU
//   mdu_done, mdu_result     MDU completion pulse and result
//   stall_ex                 hold the EX stage
//   res_valid/data/rd        buffered result for writeback
//   err_timeout              sticky watchdog flag
//   dbg_state_o              current FSM state (debug observation)
//
// Result handshake: res_valid stays high with stable res_data/res_rd until
// the cycle in which wb_ready is high; that cycle is the transfer. A flush in
// RESP drops the result without a transfer.
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic            ex_is_mul_div,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_word_op,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  input  logic            wb_ready,
  output logic            mdu_start,
  output logic [2:0]      mdu_op,
  output logic            mdu_word,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  output logic            mdu_kill,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            stall_ex,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            err_timeout,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // The watchdog fires in the TIMEOUT-th cycle spent waiting on the MDU.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              kill_q, kill_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic              res_valid_q, res_valid_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic              err_q, err_d;
  logic              issue;

  assign issue = ex_valid & ex_is_mul_div & ~flush;

  // Release EX only in the cycle where writeback takes the result.
  assign stall_ex = issue & ~((state_q == S_RESP) & wb_ready);

`ifdef MDU_FASTPATH_EN
  logic            div_zero;
  logic [XLEN-1:0] rs1_wext;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    for (int i = 0; i < XLEN; i++) begin
      rs1_wext[i] = (i < 32) ? ex_rs1[i] : ex_rs1[31];
    end
    div_zero = ex_funct3[2] &
               (ex_word_op ? (ex_rs2[31:0] == 32'd0) : (ex_rs2 == '0));
    // funct3[1] separates REM/REMU (dividend returned) from DIV/DIVU (all-ones).
    if (ex_funct3[1]) begin
      fast_res = ex_word_op ? rs1_wext : ex_rs1;
    end else begin
      fast_res = '1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    kill_d      = 1'b0;
    op_d        = op_q;
    word_d      = word_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          op_d   = ex_funct3;
          word_d = ex_word_op;
          a_d    = ex_rs1;
          b_d    = ex_rs2;
          rd_d   = ex_rd;
          cnt_d  = '0;
`ifdef MDU_FASTPATH_EN
          if (div_zero) begin
            res_valid_d = 1'b1;
            res_data_d  = fast_res;
            state_d     = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
`else
          start_d = 1'b1;
          state_d = S_BUSY;
`endif
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mdu_done && flush) begin
          // The MDU already finished, so there is nothing to abort.
          state_d = S_IDLE;
        end else if (mdu_done) begin
          res_valid_d = 1'b1;
          res_data_d  = mdu_result;
          state_d     = S_RESP;
        end else if (flush) begin
          kill_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          kill_d      = 1'b1;
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = '1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (flush || wb_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Wait for the killed op to finish before new work starts. The
        // counter keeps running, so a dead MDU cannot hold us here forever.
        cnt_d = cnt_q + CNT_W'(1);
        if (mdu_done || (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      kill_q      <= 1'b0;
      op_q        <= '0;
      word_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      kill_q      <= kill_d;
      op_q        <= op_d;
      word_q      <= word_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign mdu_start   = start_q;
  assign mdu_kill    = kill_q;
  assign mdu_op      = op_q;
  assign mdu_word    = word_q;
  assign mdu_a       = a_q;
  assign mdu_b       = b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = rd_q;
  assign err_timeout = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer
//
// Bench for mdu_sequencer at XLEN=64 with TIMEOUT=80. The bench also plays
// the MDU, so it chooses when mdu_done arrives. Directed table vectors and
// random ops run through one transaction task. Expected results come from a
// plain-arithmetic RISC-V M-extension reference function. Hand-written
// sequences cover flush/drain, the watchdog, the zero-divisor path and reset.
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;

  localparam int XL = 64;
  localparam int TO = 80;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          ex_valid, ex_is_mul_div, ex_word_op, flush, wb_ready;
  logic [2:0]    ex_funct3;
  logic [XL-1:0] ex_rs1, ex_rs2;
  logic [4:0]    ex_rd;
  logic          mdu_start, mdu_word, mdu_kill, mdu_done;
  logic [2:0]    mdu_op;
  logic [XL-1:0] mdu_a, mdu_b, mdu_result;
  logic          stall_ex, res_valid, err_timeout;
  logic [XL-1:0] res_data;
  logic [4:0]    res_rd;
  logic [1:0]    dbg_state;

  mdu_sequencer #(.XLEN(XL), .TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_is_mul_div(ex_is_mul_div),
    .ex_funct3(ex_funct3), .ex_word_op(ex_word_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .flush(flush), .wb_ready(wb_ready),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_word(mdu_word),
    .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_kill(mdu_kill),
    .mdu_done(mdu_done), .mdu_result(mdu_result),
    .stall_ex(stall_ex), .res_valid(res_valid), .res_data(res_data),
    .res_rd(res_rd), .err_timeout(err_timeout), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // RISC-V M-extension result computed directly from the ISA definition.
  function automatic logic [63:0] ref_mdu(logic [2:0] f3, logic w,
                                          logic [63:0] a, logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    logic [31:0]  r32;
    longint       sa, sb;
    int           sa32, sb32;
    logic         ovf64, ovf32;
    sa    = a;
    sb    = b;
    sa32  = a[31:0];
    sb32  = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    r     = '0;
    r32   = '0;
    p     = '0;
    if (w) begin
      case (f3)
        3'd0:    r32 = a[31:0] * b[31:0];
        3'd4:    r32 = ovf32 ? 32'h8000_0000 : sa32 / sb32;
        3'd5:    r32 = a[31:0] / b[31:0];
        3'd6:    r32 = ovf32 ? 32'd0 : sa32 % sb32;
        3'd7:    r32 = a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'd4: r = ovf64 ? 64'h8000_0000_0000_0000 : sa / sb;
        3'd5: r = a / b;
        3'd6: r = ovf64 ? 64'd0 : sa % sb;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_is_mul_div = 1'b0; flush = 1'b0;
    wb_ready = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_mul_div = 1'b1; ex_funct3 = f3; ex_word_op = w;
    ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
  endtask

  // One op without a flush. The MDU answers lat cycles after start, and
  // writeback holds off for wbd cycles.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int lat,
                        input int wbd, input logic [63:0] exp);
    drive_op(f3, w, a, b, rd);
    #1;
    chk("issue_stall", stall_ex, 1);
    cyc(); #1;
    chk("start", mdu_start, 1);
    chk("op_a", mdu_a, a);
    chk("op_b", mdu_b, b);
    chk("op_f3", mdu_op, f3);
    chk("op_word", mdu_word, w);
    for (int c = 0; c < lat; c++) begin
      cyc();
      mdu_done   = (c == lat - 1);
      mdu_result = mdu_done ? exp : {$urandom, $urandom};
      #1;
      chk("busy_stall", stall_ex, 1);
      chk("busy_no_start", mdu_start, 0);
    end
    cyc();
    mdu_done = 1'b0;
    for (int wi = 0; wi <= wbd; wi++) begin
      wb_ready = (wi == wbd);
      #1;
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, exp);
      chk("res_rd", res_rd, rd);
      chk("resp_stall", stall_ex, (wi != wbd));
      if (wi != wbd) cyc();
    end
    cyc();
    idle_inputs();
    #1;
    chk("res_cleared", res_valid, 0);
    chk("back_idle", dbg_state, ST_IDLE);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    int          lat;
    int          wbd;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  // Watchdog on the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          kill_early;

    // Hand-checked expected values.
    tbl[0] = '{3'd0, 1'b0, 64'd6, 64'd7, 5'd5, 5, 0, 64'd42};
    tbl[1] = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 1, 4, 64'd1};
    tbl[2] = '{3'd5, 1'b0, 64'd100, 64'd7, 5'd31, 3, 2, 64'd14};
    tbl[3] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd1, 2, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{3'd0, 1'b1, 64'h1_0000_0003, 64'd5, 5'd17, 4, 0, 64'd15};

    idle_inputs();
    ex_funct3 = '0; ex_word_op = 1'b0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mdu_result = '0;

    // Reset state.
    repeat (3) cyc();
    chk("rst_start", mdu_start, 0);
    chk("rst_kill", mdu_kill, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    cyc();

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].rd,
             tbl[i].lat, tbl[i].wbd, tbl[i].exp);
    end

    // Flush of a DIV in BUSY: kill, drain, later MUL waits for IDLE.
    drive_op(3'd4, 1'b0, 64'd100, 64'd3, 5'd7); #1;
    cyc(); #1;
    chk("fl_start", mdu_start, 1);
    cyc(); #1;
    cyc(); flush = 1'b1; #1;
    chk("fl_nostall", stall_ex, 0);
    cyc(); flush = 1'b0; drive_op(3'd0, 1'b0, 64'd2, 64'd3, 5'd9); #1;
    chk("fl_kill", mdu_kill, 1);
    chk("fl_drain", dbg_state, ST_DRAIN);
    chk("fl_drain_stall", stall_ex, 1);
    cyc(); #1;
    chk("fl_kill_pulse", mdu_kill, 0);
    chk("fl_no_start", mdu_start, 0);
    cyc(); mdu_done = 1'b1; mdu_result = 64'hDEAD; #1;
    chk("fl_drain_stall2", stall_ex, 1);
    cyc(); mdu_done = 1'b0; #1;
    chk("fl_no_res", res_valid, 0);
    chk("fl_idle", dbg_state, ST_IDLE);
    chk("fl_no_start2", mdu_start, 0);
    cyc(); #1;
    chk("fl_mul_start", mdu_start, 1);
    chk("fl_mul_a", mdu_a, 64'd2);
    cyc(); mdu_done = 1'b1; mdu_result = 64'd6; #1;
    cyc(); mdu_done = 1'b0; wb_ready = 1'b1; #1;
    chk("fl_mul_res", res_data, 64'd6);
    chk("fl_mul_rd", res_rd, 9);
    chk("fl_mul_release", stall_ex, 0);
    cyc(); idle_inputs(); #1;
    chk("fl_done", res_valid, 0);

    // REMW with a zero divisor.
    drive_op(3'd6, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 5'd4); #1;
    chk("fp_stall", stall_ex, 1);
    cyc(); #1;
`ifdef MDU_FASTPATH_EN
    chk("fp_no_start", mdu_start, 0);
    chk("fp_res_valid", res_valid, 1);
    chk("fp_res_data", res_data, 64'hFFFF_FFFF_8000_0001);
    chk("fp_res_rd", res_rd, 4);
`else
    chk("fp_start", mdu_start, 1);
    cyc(); mdu_done = 1'b1; mdu_result = 64'hFFFF_FFFF_8000_0001; #1;
    cyc(); mdu_done = 1'b0; #1;
    chk("fp_res_data", res_data, 64'hFFFF_FFFF_8000_0001);
`endif
    wb_ready = 1'b1; #1;
    chk("fp_release", stall_ex, 0);
    cyc(); idle_inputs(); #1;

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = (f3 == 3'd0 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} | 64'd1;
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(1, 9));
      if (f3[2] && $urandom_range(0, 7) == 0) begin
        a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        b = '1;
      end
      run_op(f3, w, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 6),
             $urandom_range(0, 3), ref_mdu(f3, w, a, b));
    end

    // mdu_done while IDLE is ignored.
    mdu_done = 1'b1; mdu_result = 64'h55; #1;
    cyc(); mdu_done = 1'b0; #1;
    chk("idle_done_ignored", res_valid, 0);
    chk("idle_done_state", dbg_state, ST_IDLE);

    // Hung MDU: kill TIMEOUT cycles after start, result all-ones.
    drive_op(3'd0, 1'b0, 64'd1, 64'd1, 5'd3); #1;
    cyc(); #1;
    chk("to_start", mdu_start, 1);
    kill_early = 0;
    for (int k = 1; k < TO; k++) begin
      cyc(); #1;
      if (mdu_kill) kill_early++;
    end
    chk("to_no_early_kill", kill_early, 0);
    cyc(); #1;
    chk("to_kill", mdu_kill, 1);
    chk("to_err", err_timeout, 1);
    chk("to_res_valid", res_valid, 1);
    chk("to_res_data", res_data, '1);
    chk("to_res_rd", res_rd, 3);
    wb_ready = 1'b1; #1;
    chk("to_release", stall_ex, 0);
    cyc(); idle_inputs(); #1;
    chk("to_err_sticky", err_timeout, 1);
    chk("to_kill_pulse", mdu_kill, 0);
    chk("to_res_cleared", res_valid, 0);

    // Asynchronous reset while BUSY.
    drive_op(3'd1, 1'b0, 64'h1234, 64'h77, 5'd21); #1;
    cyc(); #1;
    cyc(); #1;
    chk("rb_busy", dbg_state, ST_BUSY);
    reset_n = 1'b0; idle_inputs(); #1;
    chk("rb_state", dbg_state, ST_IDLE);
    chk("rb_err", err_timeout, 0);
    chk("rb_res_data", res_data, 0);
    chk("rb_res_rd", res_rd, 0);
    chk("rb_mdu_a", mdu_a, 0);
    chk("rb_mdu_op", mdu_op, 0);
    chk("rb_start", mdu_start, 0);
    chk("rb_kill", mdu_kill, 0);
    chk("rb_stall", stall_ex, 0);
    cyc();
    reset_n = 1'b1;
    cyc(); #1;
    chk("rb_idle", dbg_state, ST_IDLE);
    run_op(tbl[0].f3, tbl[0].w, tbl[0].a, tbl[0].b, tbl[0].rd,
           tbl[0].lat, tbl[0].wbd, tbl[0].exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Sequences the shared iterative multiply/divide unit (MDU) for M-extension ops that control decode marks as mul/div (writeback select = M unit).
- Sits between the EX stage and the MDU:
  - latches operands and issues a one-cycle start;
  - stalls EX until the result is accepted;
  - buffers the result for writeback;
  - handles pipeline flushes and a hung unit.
- Supports RV32 and RV64, including the W-form word ops.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- TIMEOUT, 80, maximum cycles in BUSY before the watchdog fires.
- CNT_W, 7, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_mul_div  in  1  EX instruction is an M-extension op.
- ex_funct3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_word_op  in  1  OP-32 W-form; tie low when XLEN=32.
- ex_rs1  in  XLEN  operand A.
- ex_rs2  in  XLEN  operand B.
- ex_rd  in  5  destination register.
- flush  in  1  kill the EX instruction and any op in flight.
- wb_ready  in  1  writeback accepts the result this cycle.
- mdu_start  out  1  one-cycle start pulse to the MDU.
- mdu_op  out  3  latched funct3.
- mdu_word  out  1  latched word flag.
- mdu_a  out  XLEN  latched operand A.
- mdu_b  out  XLEN  latched operand B.
- mdu_kill  out  1  one-cycle abort to the MDU.
- mdu_done  in  1  MDU result valid, single-cycle pulse.
- mdu_result  in  XLEN  MDU result.
- stall_ex  out  1  hold the EX stage.
- res_valid  out  1  buffered result valid.
- res_data  out  XLEN  buffered result.
- res_rd  out  5  buffered destination register.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, latches 0.
- States:
  - IDLE, BUSY, RESP, DRAIN.
  - Registered outputs: mdu_start, mdu_kill, res_*, err_timeout.
- Issue condition: issue = ex_valid & ex_is_mul_div & !flush.
- stall_ex (combinational): issue & !(state==RESP & wb_ready).
  - Stall is asserted in the same cycle the op first appears in EX.
- IDLE:
  - On issue: latch operands and rd, pulse mdu_start next cycle, go to BUSY, clear the counter.
- BUSY:
  - Counter increments each cycle.
  - mdu_done: capture mdu_result, go to RESP.
  - flush without mdu_done: pulse mdu_kill, go to DRAIN.
  - flush with mdu_done in the same cycle: discard the result, go to IDLE.
  - Counter reaches TIMEOUT: pulse mdu_kill, set err_timeout, load res_data = all-ones, go to RESP.
- RESP:
  - res_valid=1.
  - wb_ready: clear res_valid, go to IDLE; stall_ex drops that cycle so EX advances.
  - flush: clear res_valid, go to IDLE.
  - flush has priority over wb_ready.
- DRAIN:
  - Stays until mdu_done, which is ignored; then go to IDLE.
  - A new mul/div in EX stalls; it is not issued until IDLE.
  - Counter and timeout also apply; on timeout, go to IDLE.
- Minimum latency: op in EX at cycle 0 → mdu_start at cycle 1 → res_valid at cycle (mdu_done cycle + 1).
- No re-issue: the EX instruction changes whenever stall_ex is low and flush is clear, so an op cannot be issued twice.
- mdu_done outside BUSY/DRAIN is ignored.
- err_timeout clears only on reset.
- Asynchronous reset mid-operation returns to IDLE immediately; no kill pulse is required.

Optional Feature:
- MDU_FASTPATH_EN defined: in IDLE, an issued DIV/DIVU/REM/REMU with zero divisor bypasses the MDU.
  - Divisor is zero when rs2 == 0, or rs2[31:0] == 0 for word ops.
  - No mdu_start; go directly to RESP the next cycle.
  - Result:
    - DIV/DIVU: all-ones.
    - REM/REMU: rs1.
    - Word ops: rs1[31:0] sign-extended to XLEN.
- Undefined: every op goes through the MDU.

Test Plan:
- MUL, rs1=6, rs2=7, MDU done after 5 cycles with 42:
  - mdu_start one cycle after issue;
  - stall_ex high throughout;
  - res_valid with 42 and correct rd;
  - stall releases in the wb_ready cycle.
- DIV in BUSY, flush at cycle 3:
  - mdu_kill pulses;
  - DRAIN ignores the later mdu_done;
  - no res_valid;
  - a following MUL issues only after IDLE.
- MDU never asserts done, TIMEOUT=80:
  - mdu_kill at cycle 80;
  - err_timeout=1;
  - res_data=0xFFFFFFFF;
  - err_timeout stays set after acceptance.
- RESP with wb_ready=0 for 4 cycles:
  - res_valid and res_data held stable;
  - stall_ex high;
  - release on the first cycle wb_ready=1.
- With MDU_FASTPATH_EN, REMW, XLEN=64, rs1=0x0000_0000_8000_0001, rs2=0:
  - no mdu_start;
  - res_data=0xFFFF_FFFF_8000_0001 one cycle after issue.
  - Without the macro: mdu_start is issued.
- reset_n low while in BUSY:
  - all outputs 0 immediately;
  - IDLE after release.
